// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB-first, carry held in a flop.
// Accepts an operand pair over valid/ready and returns sum, carry-out and signed overflow.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic op_sum;
  logic op_carry;
  logic last_bit;

  // The single full-adder cell shared by every bit position.
  assign op_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign op_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so invert B and force the initial carry.
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {op_sum, sum_q[WIDTH-1:1]};
        carry_d = op_carry;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ op_carry;
          cout_d  = op_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
